mma_accumulator_buffer: RTL and testbench

MMA_ACCUMULATOR_BUFFER -- requirements
Module: mma_accumulator_buffer

---
 rtl/mma_pkg.sv | 21 ++
 rtl/acc_row_select.sv | 28 ++
 rtl/mma_accumulator_buffer.sv | 122 ++++++++++++
 tb/tb_mma_accumulator_buffer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mma_pkg.sv
// Shared types and sizing helpers for the MMA accumulator buffer.
package mma_pkg;

  // Tile life cycle: wait for start, absorb K-slices, stream rows out.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Accumulator element width for operand precision p.
  function automatic int acc_width(input int p);
    return 4 * p;
  endfunction

  // Row index width; a single-row buffer still gets a 1-bit index.
  function automatic int idx_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/acc_row_select.sv
// Picks one accumulator row for the drain port. When MMA_ACC_OUT_RELU_EN is
// defined each element is clamped to max(x, 0); otherwise it passes through.
module acc_row_select
  import mma_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 4,
  parameter int P = 8
) (
  input  logic signed [acc_width(P)-1:0] acc [M][N],
  input  logic        [idx_width(M)-1:0] idx,
  output logic signed [acc_width(P)-1:0] row [N]
);

  localparam int AW = acc_width(P);

  // Row mux followed by the optional clamp.
  always_comb begin
    for (int n = 0; n < N; n++) begin
`ifdef MMA_ACC_OUT_RELU_EN
      row[n] = acc[idx][n][AW-1] ? '0 : acc[idx][n];
`else
      row[n] = acc[idx][n];
`endif
    end
  end

endmodule

// File: rtl/mma_accumulator_buffer.sv
// Accumulator buffer sitting behind an MMA array: holds the M x N running
// sum, feeds it back as the C operand, and drains it row by row when the
// tile's last K-slice arrives. Optional output clamp: MMA_ACC_OUT_RELU_EN.
module mma_accumulator_buffer
  import mma_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 4,
  parameter int P = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           step_valid,
  input  logic                           step_last,
  output logic                           step_ready,
  input  logic signed [acc_width(P)-1:0] D [M][N],
  output logic signed [acc_width(P)-1:0] C [M][N],
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [acc_width(P)-1:0] out_row [N],
  output logic        [idx_width(M)-1:0] out_row_idx,
  output logic                           busy
);

  localparam int AW = acc_width(P);
  localparam int IW = idx_width(M);
  localparam logic [IW-1:0] LAST_ROW = IW'(M - 1);

  state_t               state, state_next;
  logic    [IW-1:0]     row;
  logic signed [AW-1:0] acc [M][N];
  logic                 clear_acc, load_acc, row_clear, row_inc;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and handshake outputs.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    step_ready = 1'b0;
    out_valid  = 1'b0;
    clear_acc  = 1'b0;
    load_acc   = 1'b0;
    row_clear  = 1'b0;
    row_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear_acc  = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        step_ready = 1'b1;
        if (step_valid) begin
          load_acc = 1'b1;
          if (step_last) begin
            row_clear  = 1'b1;
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (row == LAST_ROW) state_next = IDLE;
          else                 row_inc    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator storage: cleared on tile start, overwritten by each MMA step.
  // NOTE: this is a small flop array, not a RAM, so it takes the async reset
  // like any other state; a reset would not map onto an inferred memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < M; m++)
        for (int n = 0; n < N; n++)
          acc[m][n] <= '0;
    end else if (clear_acc) begin
      for (int m = 0; m < M; m++)
        for (int n = 0; n < N; n++)
          acc[m][n] <= '0;
    end else if (load_acc) begin
      for (int m = 0; m < M; m++)
        for (int n = 0; n < N; n++)
          acc[m][n] <= D[m][n];
    end
  end

  // Drain row counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         row <= '0;
    else if (row_clear) row <= '0;
    else if (row_inc)   row <= row + IW'(1);
  end

  assign C           = acc;
  assign busy        = (state != IDLE);
  assign out_row_idx = row;

  acc_row_select #(
    .M (M),
    .N (N),
    .P (P)
  ) u_row_select (
    .acc (acc),
    .idx (row),
    .row (out_row)
  );

endmodule

// File: tb/tb_mma_accumulator_buffer.sv
// Bench for mma_accumulator_buffer at M=N=2, P=8. A tile-level model tracks
// what the outputs must be; a negedge process compares every cycle, and the
// directed sequence adds hand-computed literal expectations.
module tb_mma_accumulator_buffer;

  localparam int M  = 2;
  localparam int N  = 2;
  localparam int P  = 8;
  localparam int AW = 4 * P;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, step_valid = 1'b0, step_last = 1'b0, out_ready = 1'b0;
  logic signed [AW-1:0] d [M][N];
  logic signed [AW-1:0] c [M][N];
  logic signed [AW-1:0] out_row [N];
  logic step_ready, out_valid, busy;
  logic [0:0] out_row_idx;

  int checks = 0;
  int failures = 0;
  int rows_seen = 0;
  int idx_q [$];

  always #5 clk = ~clk;

  mma_accumulator_buffer #(.M(M), .N(N), .P(P)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .step_valid  (step_valid),
    .step_last   (step_last),
    .step_ready  (step_ready),
    .D           (d),
    .C           (c),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .busy        (busy)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint drained(input longint v);
`ifdef MMA_ACC_OUT_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Tile-level model: 0 = no tile, 1 = collecting slices, 2 = emitting rows.
  int     m_phase = 0;
  int     m_row = 0;
  longint m_acc [M][N] = '{default: 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_row   = 0;
      foreach (m_acc[i, j]) m_acc[i][j] = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
             foreach (m_acc[i, j]) m_acc[i][j] = 0;
             m_phase = 1;
           end
        1: if (step_valid) begin
             foreach (m_acc[i, j]) m_acc[i][j] = d[i][j];
             if (step_last) begin
               m_row   = 0;
               m_phase = 2;
             end
           end
        default: if (out_ready) begin
             if (m_row == M - 1) m_phase = 0;
             else                m_row   = m_row + 1;
           end
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("busy", busy, m_phase != 0);
    check("step_ready", step_ready, m_phase == 1);
    check("out_valid", out_valid, m_phase == 2);
    foreach (m_acc[i, j]) check($sformatf("C[%0d][%0d]", i, j), c[i][j], m_acc[i][j]);
    if (m_phase == 2) begin
      check("out_row_idx", out_row_idx, m_row);
      for (int j = 0; j < N; j++)
        check($sformatf("out_row[%0d]", j), out_row[j], drained(m_acc[m_row][j]));
    end else begin
      check("out_row_idx_idle", out_row_idx, (m_phase == 0 && !rst_n) ? 0 : out_row_idx);
    end
    if (out_valid && out_ready) begin
      rows_seen++;
      idx_q.push_back(int'(out_row_idx));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input longint a, input longint b, input longint e, input longint f);
    d[0][0] = AW'(a);
    d[0][1] = AW'(b);
    d[1][0] = AW'(e);
    d[1][1] = AW'(f);
  endtask

  initial begin
    set_d(0, 0, 0, 0);

    // Reset state.
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_step_ready", step_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_idx", out_row_idx, 0);
    rst_n = 1'b1;
    tick();

    // Tile 1: D = 5, 10, 15 with last on the third, full-rate drain.
    rows_seen = 0;
    idx_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy_after_start", busy, 1);
    check("t1_ready_after_start", step_ready, 1);
    check("t1_C_cleared", c[1][1], 0);
    step_valid = 1'b1;
    set_d(5, 5, 5, 5);
    tick();
    set_d(10, 10, 10, 10);
    tick();
    set_d(15, 15, 15, 15);
    step_last = 1'b1;
    out_ready = 1'b1;
    tick();
    step_valid = 1'b0;
    step_last  = 1'b0;
    check("t1_C_after_last", c[0][1], 15);
    check("t1_out_valid", out_valid, 1);
    check("t1_idx0", out_row_idx, 0);
    check("t1_row0", out_row[0], 15);
    tick();
    check("t1_idx1", out_row_idx, 1);
    check("t1_row1", out_row[1], 15);
    tick();
    check("t1_busy_done", busy, 0);
    check("t1_C_held", c[1][0], 15);
    check("t1_rows", rows_seen, 2);
    if (idx_q.size() == 2) begin
      check("t1_idx_seq0", idx_q[0], 0);
      check("t1_idx_seq1", idx_q[1], 1);
    end else begin
      check("t1_idx_count", idx_q.size(), 2);
    end

    // Tile 2: distinct elements, negative value, stalled drain with
    // stray start/step_valid that must be ignored.
    out_ready = 1'b0;
    rows_seen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_C_cleared", c[0][0], 0);
    step_valid = 1'b1;
    set_d(1, 2, 3, 4);
    tick();
    check("t2_C11", c[1][1], 4);
    set_d(-3, 100, 7, -8);
    step_last = 1'b1;
    tick();
    step_last = 1'b0;
    set_d(7, 7, 7, 7);
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_stall_idx", out_row_idx, 0);
`ifdef MMA_ACC_OUT_RELU_EN
      check("t2_stall_row0", out_row[0], 0);
`else
      check("t2_stall_row0", out_row[0], -3);
`endif
      check("t2_stall_row1", out_row[1], 100);
      check("t2_C_unclamped", c[0][0], -3);
    end
    step_valid = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t2_idx_after_accept", out_row_idx, 1);
    check("t2_row1_0", out_row[0], 7);
`ifdef MMA_ACC_OUT_RELU_EN
    check("t2_row1_1", out_row[1], 0);
`else
    check("t2_row1_1", out_row[1], -8);
`endif
    tick();
    out_ready = 1'b0;
    check("t2_idle", busy, 0);
    step_valid = 1'b1;
    step_last = 1'b1;
    repeat (3) tick();
    step_valid = 1'b0;
    step_last = 1'b0;
    check("t2_idle_C", c[0][1], 100);
    check("t2_idle_no_rows", out_valid, 0);
    check("t2_rows", rows_seen, 2);

    // Tile 3: lone step_last ignored, then reset mid-drain after row 0.
    rows_seen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    step_last = 1'b1;
    tick();
    check("t3_last_alone_busy", step_ready, 1);
    check("t3_last_alone_no_drain", out_valid, 0);
    step_valid = 1'b1;
    set_d(9, 9, 9, 9);
    out_ready = 1'b1;
    tick();
    step_valid = 1'b0;
    step_last = 1'b0;
    tick();
    check("t3_at_row1", out_row_idx, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t3_rst_busy", busy, 0);
    check("t3_rst_out_valid", out_valid, 0);
    check("t3_rst_step_ready", step_ready, 0);
    check("t3_rst_idx", out_row_idx, 0);
    check("t3_rst_C", c[0][0], 0);
    check("t3_rst_row", out_row[1], 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t3_rows", rows_seen, 1);
    check("t3_idle", busy, 0);

    // Tile 4: clean restart after the aborted tile.
    rows_seen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    step_valid = 1'b1;
    step_last = 1'b1;
    set_d(11, 12, 13, 14);
    tick();
    step_valid = 1'b0;
    step_last = 1'b0;
    repeat (2) tick();
    check("t4_rows", rows_seen, 2);
    check("t4_idle", busy, 0);
    check("t4_C", c[1][0], 13);
    out_ready = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
